// File: rtl/rope_contact_mux.sv
`default_nettype none
// ============================================================================
// Module   : rope_contact_mux
// Brief    : Final pixel colour mux plus player/rope overlap detection with a
//            per-frame debounced grab/release state machine.
// Revision : 1.0 - initial release
// ============================================================================
module rope_contact_mux #(
    parameter int GRAB_FRAMES    = 2,
    parameter int RELEASE_FRAMES = 3
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        playerDR,
    input  logic [7:0]  playerRGB,
    input  logic        ropeDR,
    input  logic [7:0]  ropeRGB,
    input  logic [7:0]  bgRGB,
    output logic [7:0]  RGBout,
    output logic        collision,
    output logic [10:0] contactX,
    output logic [10:0] contactY,
    output logic        onRope,
    output logic        grabPulse,
    output logic        releasePulse
);

    localparam logic [3:0] C_GRAB_CNT    = 4'(GRAB_FRAMES);
    localparam logic [3:0] C_RELEASE_CNT = 4'(RELEASE_FRAMES);

    generate
        if (GRAB_FRAMES < 1 || GRAB_FRAMES > 15) begin : g_bad_grab
            $error("rope_contact_mux: GRAB_FRAMES must be in 1..15");
        end
        if (RELEASE_FRAMES < 1 || RELEASE_FRAMES > 15) begin : g_bad_release
            $error("rope_contact_mux: RELEASE_FRAMES must be in 1..15");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_FREE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    logic        w_hit;
    logic        w_first_hit;
    logic        frameHit_q;
    logic        frameHit_d;
    logic [7:0]  RGBout_q;
    logic        collision_q;
    logic [10:0] capX_q;
    logic [10:0] capY_q;
    logic [10:0] contactX_q;
    logic [10:0] contactY_q;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        onRope_q;
    logic        grabPulse_q;
    logic        releasePulse_q;

    // A hit on the startOfFrame cycle opens the new frame, so it is always a first hit.
    assign w_hit       = playerDR & ropeDR;
    assign w_first_hit = w_hit & (~frameHit_q | startOfFrame);
    assign frameHit_d  = startOfFrame ? w_hit : (frameHit_q | w_hit);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            RGBout_q    <= 8'h00;
            collision_q <= 1'b0;
            frameHit_q  <= 1'b0;
            capX_q      <= 11'd0;
            capY_q      <= 11'd0;
            contactX_q  <= 11'd0;
            contactY_q  <= 11'd0;
        end else begin
            RGBout_q    <= playerDR ? playerRGB : (ropeDR ? ropeRGB : bgRGB);
            collision_q <= w_first_hit;
            frameHit_q  <= frameHit_d;
            if (w_first_hit) begin
                capX_q <= pixelX;
                capY_q <= pixelY;
            end
            // Old capture is published before a coincident first hit overwrites it.
            if (startOfFrame && frameHit_q) begin
                contactX_q <= capX_q;
                contactY_q <= capY_q;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= S_FREE;
            cnt_q          <= 4'd0;
            onRope_q       <= 1'b0;
            grabPulse_q    <= 1'b0;
            releasePulse_q <= 1'b0;
        end else begin
            grabPulse_q    <= 1'b0;
            releasePulse_q <= 1'b0;
            if (startOfFrame) begin
                if (state_q == S_FREE) begin
                    if (frameHit_q) begin
                        if (cnt_q + 4'd1 == C_GRAB_CNT) begin
                            state_q     <= S_HOLD;
                            cnt_q       <= 4'd0;
                            onRope_q    <= 1'b1;
                            grabPulse_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= 4'd0;
                    end
                end else begin
                    if (!frameHit_q) begin
                        if (cnt_q + 4'd1 == C_RELEASE_CNT) begin
                            state_q        <= S_FREE;
                            cnt_q          <= 4'd0;
                            onRope_q       <= 1'b0;
                            releasePulse_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= 4'd0;
                    end
                end
            end
        end
    end

    assign RGBout       = RGBout_q;
    assign collision    = collision_q;
    assign contactX     = contactX_q;
    assign contactY     = contactY_q;
    assign onRope       = onRope_q;
    assign grabPulse    = grabPulse_q;
    assign releasePulse = releasePulse_q;

endmodule
`default_nettype wire
